// File: rtl/dmac_master_engine_if.sv
// dmac_master_engine_if: shared-bus master/slave signal bundle for the DMA transfer engine.
interface dmac_master_engine_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic              m_req;
    logic              m_sel;
    logic              m_wr;
    logic              m_grant;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_dout;
    logic [DATA_W-1:0] m_din;
    modport master (output m_req, m_sel, m_wr, m_addr, m_dout, input m_grant, m_din);
    modport slave  (input m_req, m_sel, m_wr, m_addr, m_dout, output m_grant, m_din);
endinterface

// File: rtl/dmac_master_engine.sv
// dmac_master_engine: DMA transfer engine copying data_size words src->dest as read/write pairs.
// Optional feature: define DMAC_ABORT_EN to add the op_abort input.
module dmac_master_engine #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_start,
    input  logic [1:0]  opmode,
    input  logic [31:0] src_addr,
    input  logic [31:0] dest_addr,
    input  logic [31:0] data_size,
    input  logic        opdone_clear,
`ifdef DMAC_ABORT_EN
    input  logic        op_abort,
`endif
    output logic        opdone,
    output logic        busy,
    dmac_master_engine_if.master bus
);
    typedef enum logic [2:0] {IDLE, REQ, READ, RD_WAIT, WRITE} state_t;
    state_t            state;
    logic [ADDR_W-1:0] cur_src;
    logic [ADDR_W-1:0] cur_dst;
    logic [31:0]       remain;
    logic [1:0]        mode;
    logic [DATA_W-1:0] data;
    logic              abort;
    logic              last;
    logic              unused_addr_hi;
`ifdef DMAC_ABORT_EN
    assign abort = op_abort;
`else
    assign abort = 1'b0;
`endif
    assign unused_addr_hi = ^{src_addr, dest_addr};
    assign last = remain == 32'd1;
    // Bus strobes decode straight from state so a lost grant or reset drops them at once.
    assign busy = state != IDLE;
    assign bus.m_req = busy;
    assign bus.m_sel = bus.m_grant & (state == READ || state == WRITE);
    assign bus.m_wr = bus.m_grant & (state == WRITE);
    assign bus.m_addr = state == READ ? cur_src : state == WRITE ? cur_dst : '0;
    assign bus.m_dout = data;
    // Transfer sequencing: latch the job, then alternate read/write per word until remain runs out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cur_src <= '0;
            cur_dst <= '0;
            remain  <= '0;
            mode    <= '0;
            data    <= '0;
            opdone  <= 1'b0;
        end else begin
            if (opdone_clear) opdone <= 1'b0;
            case (state)
                IDLE: if (op_start) begin
                    if (data_size == 32'd0) opdone <= 1'b1;
                    else begin
                        cur_src <= src_addr[ADDR_W-1:0];
                        cur_dst <= dest_addr[ADDR_W-1:0];
                        remain  <= data_size;
                        mode    <= opmode;
                        opdone  <= 1'b0;
                        state   <= REQ;
                    end
                end
                REQ:  state <= abort ? IDLE : bus.m_grant ? READ : REQ;
                READ: state <= abort ? IDLE : bus.m_grant ? RD_WAIT : READ;
                RD_WAIT: begin
                    data  <= bus.m_din;
                    state <= abort ? IDLE : WRITE;
                end
                WRITE: if (bus.m_grant) begin
                    remain  <= remain - 32'd1;
                    cur_src <= mode[0] ? cur_src : cur_src + ADDR_W'(1);
                    cur_dst <= mode[1] ? cur_dst : cur_dst + ADDR_W'(1);
                    if (last && !abort) opdone <= 1'b1;
                    state <= (last || abort) ? IDLE : READ;
                end else if (abort) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmac_master_engine.sv
// tb_dmac_master_engine: table-driven and sequence checks of the DMA engine against a bus scoreboard.
module tb_dmac_master_engine;
    typedef struct {
        logic [31:0] src;
        logic [31:0] dst;
        logic [31:0] size;
        logic [1:0]  mode;
        int          cyc;
    } vec_t;
    typedef struct {
        logic [15:0] addr;
        logic [31:0] data;
    } wexp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        op_start = 1'b0;
    logic [1:0]  opmode = '0;
    logic [31:0] src_addr = '0;
    logic [31:0] dest_addr = '0;
    logic [31:0] data_size = '0;
    logic        opdone_clear = 1'b0;
    logic        opdone;
    logic        busy;
`ifdef DMAC_ABORT_EN
    logic        op_abort = 1'b0;
`endif
    int          checks = 0;
    int          errors = 0;
    logic [15:0] rd_q[$];
    wexp_t       wr_q[$];
    wexp_t       we;
    vec_t        tbl[5];

    dmac_master_engine_if #(.ADDR_W(16), .DATA_W(32)) bus ();

    dmac_master_engine #(.ADDR_W(16), .DATA_W(32)) dut (
        .clk(clk),
        .reset(reset),
        .op_start(op_start),
        .opmode(opmode),
        .src_addr(src_addr),
        .dest_addr(dest_addr),
        .data_size(data_size),
        .opdone_clear(opdone_clear),
`ifdef DMAC_ABORT_EN
        .op_abort(op_abort),
`endif
        .opdone(opdone),
        .busy(busy),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [15:0] s, input logic [15:0] d, input int n, input int nrd,
                        input int nwr, input logic [1:0] m);
        logic [15:0] a = s;
        logic [15:0] b = d;
        for (int i = 0; i < n; i++) begin
            if (i < nrd) rd_q.push_back(a);
            if (i < nwr) wr_q.push_back(wexp_t'{b, 32'hA0 + 32'(a)});
            if (!m[0]) a++;
            if (!m[1]) b++;
        end
    endtask

    // Bus monitor and memory model: m_din returns 0xA0 + read address
    always @(negedge clk) begin
        if (!reset && bus.m_sel) begin
            if (bus.m_wr) begin
                if (wr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL wr_extra actual=write@%0h required=none", bus.m_addr);
                end else begin
                    we = wr_q.pop_front();
                    chk("wr_addr", 64'(bus.m_addr), 64'(we.addr));
                    chk("wr_data", 64'(bus.m_dout), 64'(we.data));
                end
            end else begin
                if (rd_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rd_extra actual=read@%0h required=none", bus.m_addr);
                end else chk("rd_addr", 64'(bus.m_addr), 64'(rd_q.pop_front()));
                bus.m_din = 32'hA0 + 32'(bus.m_addr);
            end
        end
    end

    task automatic start(input logic [31:0] s, input logic [31:0] d, input logic [31:0] n, input logic [1:0] m);
        @(negedge clk);
        src_addr = s;
        dest_addr = d;
        data_size = n;
        opmode = m;
        op_start = 1'b1;
        @(posedge clk);
        #1;
        op_start = 1'b0;
    endtask

    task automatic run_xfer(input vec_t v);
        int n = 0;
        push(v.src[15:0], v.dst[15:0], int'(v.size), int'(v.size), int'(v.size), v.mode);
        start(v.src, v.dst, v.size, v.mode);
        op_start = 1'b1;
        src_addr = 32'h1234;
        dest_addr = 32'h5678;
        data_size = 32'd9;
        opmode = 2'b11;
        while (opdone !== 1'b1 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
            op_start = 1'b0;
        end
        chk("done_cycles", 64'(n), 64'(v.cyc));
        chk("busy_after", 64'(busy), 64'd0);
        chk("req_after", 64'(bus.m_req), 64'd0);
        chk("rd_left", 64'(rd_q.size()), 64'd0);
        chk("wr_left", 64'(wr_q.size()), 64'd0);
    endtask

    initial begin
        tbl[0] = '{32'h10, 32'h20, 32'd3, 2'b00, 10};
        tbl[1] = '{32'h5, 32'h7, 32'd2, 2'b11, 7};
        tbl[2] = '{32'hFFFF, 32'h30, 32'd2, 2'b00, 7};
        tbl[3] = '{32'h40, 32'hFFFF, 32'd1, 2'b01, 4};
        tbl[4] = '{32'h1_0080, 32'h90, 32'd3, 2'b10, 10};
        bus.m_grant = 1'b1;
        bus.m_din = '0;
        #2;
        chk("rst_req", 64'(bus.m_req), 64'd0);
        chk("rst_sel", 64'(bus.m_sel), 64'd0);
        chk("rst_wr", 64'(bus.m_wr), 64'd0);
        chk("rst_addr", 64'(bus.m_addr), 64'd0);
        chk("rst_dout", 64'(bus.m_dout), 64'd0);
        chk("rst_opdone", 64'(opdone), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) run_xfer(tbl[i]);

        @(negedge clk);
        opdone_clear = 1'b1;
        @(posedge clk);
        #1;
        opdone_clear = 1'b0;
        chk("clear_opdone", 64'(opdone), 64'd0);
        start(32'h100, 32'h200, 32'd0, 2'b00);
        chk("zero_opdone", 64'(opdone), 64'd1);
        chk("zero_busy", 64'(busy), 64'd0);
        chk("zero_req", 64'(bus.m_req), 64'd0);
        @(posedge clk);
        #1;
        chk("zero_busy2", 64'(busy), 64'd0);
        chk("zero_req2", 64'(bus.m_req), 64'd0);

        push(16'h50, 16'h60, 2, 2, 2, 2'b00);
        start(32'h50, 32'h60, 32'd2, 2'b00);
        repeat (3) @(posedge clk);
        #1;
        bus.m_grant = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("stall_sel", 64'(bus.m_sel), 64'd0);
            chk("stall_addr", 64'(bus.m_addr), 64'h60);
            chk("stall_dout", 64'(bus.m_dout), 64'hF0);
            chk("stall_busy", 64'(busy), 64'd1);
            @(posedge clk);
        end
        #1;
        bus.m_grant = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        opdone_clear = 1'b1;
        @(posedge clk);
        #1;
        chk("set_wins", 64'(opdone), 64'd1);
        chk("stall_done_busy", 64'(busy), 64'd0);
        chk("stall_wr_left", 64'(wr_q.size()), 64'd0);
        @(posedge clk);
        #1;
        opdone_clear = 1'b0;
        chk("clear_after", 64'(opdone), 64'd0);

`ifdef DMAC_ABORT_EN
        push(16'h70, 16'h80, 4, 2, 1, 2'b00);
        start(32'h70, 32'h80, 32'd4, 2'b00);
        repeat (5) @(posedge clk);
        #1;
        op_abort = 1'b1;
        @(posedge clk);
        #1;
        op_abort = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_opdone", 64'(opdone), 64'd0);
        repeat (4) @(posedge clk);
        #1;
        chk("abort_busy2", 64'(busy), 64'd0);
        chk("abort_rd_left", 64'(rd_q.size()), 64'd0);
        chk("abort_wr_left", 64'(wr_q.size()), 64'd0);
`endif

        push(16'hA0, 16'hB0, 2, 1, 0, 2'b00);
        start(32'hA0, 32'hB0, 32'd2, 2'b00);
        repeat (3) @(posedge clk);
        #1;
        chk("pre_rst_sel", 64'(bus.m_sel), 64'd1);
        reset = 1'b1;
        #1;
        chk("mrst_req", 64'(bus.m_req), 64'd0);
        chk("mrst_sel", 64'(bus.m_sel), 64'd0);
        chk("mrst_wr", 64'(bus.m_wr), 64'd0);
        chk("mrst_addr", 64'(bus.m_addr), 64'd0);
        chk("mrst_dout", 64'(bus.m_dout), 64'd0);
        chk("mrst_busy", 64'(busy), 64'd0);
        chk("mrst_opdone", 64'(opdone), 64'd0);
        chk("mrst_rd_left", 64'(rd_q.size()), 64'd0);
        wr_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_busy", 64'(busy), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
